// File: rtl/regfile_pkg.sv
// Shared constants, pointer type and round-robin helper for the register file writeback slice.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Wide enough for up to four requesters.
    typedef logic [1:0] ptr_t;

    function automatic ptr_t rr_next(input ptr_t ptr, input int n);
        if (int'(ptr) >= n - 1) begin
            return '0;
        end
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) gets a one-hot grant.
import regfile_pkg::*;

module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  ptr_t         ptr,
    output logic [N-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && (j == (int'(ptr) + k) % N) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NUM_REQ writeback sources and tracks pending writes.
// Define REGFILE_BYPASS_EN to add same-cycle forwarding outputs from the write stage.
import regfile_pkg::*;

module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
`ifdef REGFILE_BYPASS_EN
    output logic                      rs1_fwd_valid,
    output logic [DATA_W-1:0]         rs1_fwd_data,
    output logic                      rs2_fwd_valid,
    output logic [DATA_W-1:0]         rs2_fwd_data,
`endif
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data
);

    ptr_t                 ptr;
    logic [NUM_REQ-1:0]   gnt;
    logic                 xfer;
    ptr_t                 grant_idx;
    logic [ADDR_W-1:0]    grant_addr;
    logic [DATA_W-1:0]    grant_data;
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign req_ready = rst ? '0 : gnt;

    always_comb begin
        xfer       = |req_ready;
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_idx  = ptr_t'(i);
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A new issue to the same register overrides the clear from an older producer's writeback.
    always_comb begin
        busy_next = busy;
        if (xfer) begin
            busy_next[grant_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            busy    <= '0;
        end else begin
            busy <= busy_next;
            if (xfer) begin
                ptr     <= rr_next(grant_idx, NUM_REQ);
                wb_en   <= (grant_addr != REG_ZERO);
                wb_addr <= grant_addr;
                wb_data <= grant_data;
            end else begin
                wb_en <= 1'b0;
            end
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    assign rs1_fwd_valid = wb_en && (wb_addr == rs1_addr) && (rs1_addr != REG_ZERO);
    assign rs1_fwd_data  = wb_data;
    assign rs2_fwd_valid = wb_en && (wb_addr == rs2_addr) && (rs2_addr != REG_ZERO);
    assign rs2_fwd_data  = wb_data;
`endif

endmodule
